// File: rtl/int_stim_pkg.sv
// Shared types and constants for the interrupt stimulus generator.
package int_stim_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAssert = 2'd1,
    StDone   = 2'd2
  } chan_state_e;

  localparam logic [31:0] ACK_ADDR_DEFAULT = 32'h0000_7f20;
  localparam logic [31:0] PC_MASK          = 32'hffff_fffc;

endpackage

// File: rtl/int_stim_chan.sv
// One interrupt channel: fire on PC match, hold until acked, limit total fires.
// Optional ack-wait timeout is built only when INT_STIM_TIMEOUT_EN is defined.
module int_stim_chan
  import int_stim_pkg::*;
#(
  parameter int unsigned CNT_W = 8
`ifdef INT_STIM_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 1024
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      i_pc,
  input  logic             i_cfg_we,
  input  logic [31:0]      i_cfg_target,
  input  logic [CNT_W-1:0] i_cfg_max,
  input  logic             i_ack,
  output logic             o_assert_next,
  output logic             o_timeout_err
);

  chan_state_e      r_state, w_state_next;
  logic [31:0]      r_target;
  logic [CNT_W-1:0] r_max;
  logic [CNT_W-1:0] r_fires;
  logic             r_armed;
  logic             w_match;
  logic             w_tmo_hit;

  assign w_match = (r_state == StIdle) && r_armed && (i_pc == r_target) && (r_fires < r_max);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (i_cfg_we) begin
      w_state_next = StIdle;
    end else begin
      case (r_state)
        StIdle:   if (w_match) w_state_next = StAssert;
        StAssert: begin
          if (i_ack)          w_state_next = (r_fires == r_max) ? StDone : StIdle;
          else if (w_tmo_hit) w_state_next = StIdle;
        end
        StDone:   w_state_next = StDone;
        default:  w_state_next = StIdle;
      endcase
    end
  end

  always_comb begin
    o_assert_next = (w_state_next == StAssert);
  end

  // Entering ASSERT implies w_match, so fires can never pass max.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_target <= '0;
      r_max    <= '0;
      r_fires  <= '0;
      r_armed  <= 1'b1;
    end else if (i_cfg_we) begin
      r_target <= i_cfg_target;
      r_max    <= i_cfg_max;
      r_fires  <= '0;
      r_armed  <= 1'b1;
    end else if (w_match) begin
      r_fires  <= r_fires + 1'b1;
      r_armed  <= 1'b0;
    end else if (i_pc != r_target) begin
      r_armed  <= 1'b1;
    end
  end

`ifdef INT_STIM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_tmo_err;

  assign w_tmo_hit = (r_state == StAssert) && (r_tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_tmo_cnt <= ((r_state == StAssert) && (w_state_next == StAssert)) ? r_tmo_cnt + 1'b1 : '0;
      if (i_cfg_we)                r_tmo_err <= 1'b0;
      else if (w_tmo_hit && !i_ack) r_tmo_err <= 1'b1;
    end
  end

  assign o_timeout_err = r_tmo_err;
`else
  assign w_tmo_hit     = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

endmodule

// File: rtl/int_stim_gen.sv
// Multi-channel PC-triggered interrupt generator: channels, ack decode, priority
// encoder and registered outputs. Timeout support via INT_STIM_TIMEOUT_EN.
module int_stim_gen
  import int_stim_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned CNT_W    = 8,
  parameter logic [31:0] ACK_ADDR = ACK_ADDR_DEFAULT,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      macroscopic_pc,
  input  logic [31:0]      m_int_addr,
  input  logic [3:0]       m_int_byteen,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_ch,
  input  logic [31:0]      cfg_target,
  input  logic [CNT_W-1:0] cfg_max,
  output logic             interrupt,
  output logic [2:0]       int_id,
  output logic [NCH-1:0]   pending,
  output logic [NCH-1:0]   timeout_err
);

  if (NCH < 1 || NCH > 8 || TIMEOUT < 1) begin : g_param_check
    $error("int_stim_gen: NCH must be 1..8 and TIMEOUT at least 1");
  end

  logic [31:0]    w_pc;
  logic           w_ack;
  logic [NCH-1:0] w_assert_next;
  logic [2:0]     w_id_next;
  logic           r_interrupt;
  logic [2:0]     r_int_id;
  logic [NCH-1:0] r_pending;

  assign w_pc  = macroscopic_pc & PC_MASK;
  assign w_ack = (|m_int_byteen) && ((m_int_addr & PC_MASK) == (ACK_ADDR & PC_MASK));

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    int_stim_chan #(
      .CNT_W         (CNT_W)
`ifdef INT_STIM_TIMEOUT_EN
      ,
      .TIMEOUT       (TIMEOUT)
`endif
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .i_pc          (w_pc),
      .i_cfg_we      (cfg_we && (cfg_ch == 3'(g))),
      .i_cfg_target  (cfg_target),
      .i_cfg_max     (cfg_max),
      .i_ack         (w_ack && r_pending[g] && (r_int_id == 3'(g))),
      .o_assert_next (w_assert_next[g]),
      .o_timeout_err (timeout_err[g])
    );
  end

  // Lowest asserting channel wins; scan downward so the last hit is the lowest.
  always_comb begin
    w_id_next = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_assert_next[i]) w_id_next = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_interrupt <= 1'b0;
      r_int_id    <= '0;
      r_pending   <= '0;
    end else begin
      r_interrupt <= |w_assert_next;
      r_int_id    <= w_id_next;
      r_pending   <= w_assert_next;
    end
  end

  assign interrupt = r_interrupt;
  assign int_id    = r_int_id;
  assign pending   = r_pending;

endmodule

// File: tb/tb_int_stim_gen.sv
// Directed self-checking bench for int_stim_gen (timeout case under INT_STIM_TIMEOUT_EN).
module tb_int_stim_gen;

  localparam int unsigned NCH   = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      macroscopic_pc = 32'h1000;
  logic [31:0]      m_int_addr = 32'h0;
  logic [3:0]       m_int_byteen = 4'h0;
  logic             cfg_we = 1'b0;
  logic [2:0]       cfg_ch = 3'd0;
  logic [31:0]      cfg_target = 32'h0;
  logic [CNT_W-1:0] cfg_max = '0;
  logic             interrupt;
  logic [2:0]       int_id;
  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  int_stim_gen #(
    .NCH      (NCH),
    .CNT_W    (CNT_W),
    .ACK_ADDR (32'h0000_7f20),
    .TIMEOUT  (8)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .macroscopic_pc (macroscopic_pc),
    .m_int_addr     (m_int_addr),
    .m_int_byteen   (m_int_byteen),
    .cfg_we         (cfg_we),
    .cfg_ch         (cfg_ch),
    .cfg_target     (cfg_target),
    .cfg_max        (cfg_max),
    .interrupt      (interrupt),
    .int_id         (int_id),
    .pending        (pending),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cfg_load(input logic [2:0] ch, input logic [31:0] tgt, input logic [7:0] mx);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_target = tgt;
    cfg_max    = mx;
    tick();
    cfg_we     = 1'b0;
  endtask

  task automatic ack_store(input logic [31:0] addr, input logic [3:0] be);
    m_int_addr   = addr;
    m_int_byteen = be;
    tick();
    m_int_byteen = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    #1;
    check_val("rst_interrupt", 32'(interrupt), 32'd0);
    check_val("rst_int_id", 32'(int_id), 32'd0);
    check_val("rst_pending", 32'(pending), 32'd0);
    check_val("rst_timeout_err", 32'(timeout_err), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Single fire, ack, no refire once limit is reached
    cfg_load(3'd0, 32'h3010, 8'd1);
    macroscopic_pc = 32'h3010;
    tick();
    macroscopic_pc = 32'h1000;
    check_val("t1_int", 32'(interrupt), 32'd1);
    check_val("t1_id", 32'(int_id), 32'd0);
    check_val("t1_pend", 32'(pending), 32'h1);
    ack_store(32'h7f20, 4'hf);
    check_val("t1_ack", 32'(interrupt), 32'd0);
    macroscopic_pc = 32'h3010;
    tick();
    tick();
    macroscopic_pc = 32'h1000;
    check_val("t1_norefire", 32'(interrupt), 32'd0);

    // Two channels on one target, serviced in priority order
    cfg_load(3'd1, 32'h3020, 8'd2);
    cfg_load(3'd2, 32'h3020, 8'd2);
    macroscopic_pc = 32'h3020;
    tick();
    macroscopic_pc = 32'h1000;
    check_val("t2_pend", 32'(pending), 32'h6);
    check_val("t2_id", 32'(int_id), 32'd1);
    ack_store(32'h7f20, 4'hf);
    check_val("t2_id_after_ack", 32'(int_id), 32'd2);
    check_val("t2_pend_after_ack", 32'(pending), 32'h4);
    ack_store(32'h7f20, 4'hf);
    check_val("t2_int_cleared", 32'(interrupt), 32'd0);

    // Ack and a new match on another channel in the same cycle
    cfg_load(3'd3, 32'h3030, 8'd1);
    macroscopic_pc = 32'h3020;
    tick();
    macroscopic_pc = 32'h1000;
    check_val("t3_pend", 32'(pending), 32'h6);
    macroscopic_pc = 32'h3030;
    ack_store(32'h7f20, 4'hf);
    macroscopic_pc = 32'h1000;
    check_val("t3_pend_mix", 32'(pending), 32'hc);
    check_val("t3_id_mix", 32'(int_id), 32'd2);
    ack_store(32'h7f20, 4'hf);
    check_val("t3_id_ch3", 32'(int_id), 32'd3);
    ack_store(32'h7f20, 4'hf);
    check_val("t3_int_cleared", 32'(interrupt), 32'd0);

    // PC held on target (low bits ignored) fires once; leaving and returning refires
    cfg_load(3'd0, 32'h3010, 8'd3);
    macroscopic_pc = 32'h3011;
    tick();
    check_val("t4_fire1", 32'(interrupt), 32'd1);
    ack_store(32'h7f20, 4'hf);
    check_val("t4_ack_beats_match", 32'(interrupt), 32'd0);
    tick();
    tick();
    tick();
    check_val("t4_held_nofire", 32'(interrupt), 32'd0);
    macroscopic_pc = 32'h3014;
    tick();
    macroscopic_pc = 32'h3010;
    tick();
    macroscopic_pc = 32'h1000;
    check_val("t4_fire2", 32'(interrupt), 32'd1);
    ack_store(32'h7f20, 4'hf);
    check_val("t4_ack2", 32'(interrupt), 32'd0);

    // Non-ack stores leave the interrupt up; low address bits are masked
    macroscopic_pc = 32'h3010;
    tick();
    macroscopic_pc = 32'h1000;
    check_val("t5_fire3", 32'(interrupt), 32'd1);
    ack_store(32'h7f24, 4'hf);
    check_val("t5_wrong_addr", 32'(interrupt), 32'd1);
    ack_store(32'h7f20, 4'h0);
    check_val("t5_no_byteen", 32'(interrupt), 32'd1);
    ack_store(32'h7f23, 4'h1);
    check_val("t5_masked_ack", 32'(interrupt), 32'd0);
    macroscopic_pc = 32'h3010;
    tick();
    tick();
    macroscopic_pc = 32'h1000;
    check_val("t5_saturated", 32'(interrupt), 32'd0);

    // Out-of-range channel ignored; reconfiguration aborts an active interrupt
    cfg_load(3'd5, 32'h3050, 8'd1);
    macroscopic_pc = 32'h3050;
    tick();
    macroscopic_pc = 32'h1000;
    check_val("t6_bad_ch", 32'(interrupt), 32'd0);
    cfg_load(3'd2, 32'h3060, 8'd1);
    macroscopic_pc = 32'h3060;
    tick();
    macroscopic_pc = 32'h1000;
    check_val("t6_fire", 32'(interrupt), 32'd1);
    cfg_load(3'd2, 32'h3070, 8'd1);
    check_val("t6_cfg_abort", 32'(interrupt), 32'd0);

`ifdef INT_STIM_TIMEOUT_EN
    cfg_load(3'd0, 32'h3080, 8'd2);
    macroscopic_pc = 32'h3080;
    tick();
    macroscopic_pc = 32'h1000;
    check_val("t7_fire", 32'(interrupt), 32'd1);
    repeat (7) tick();
    check_val("t7_still_high", 32'(interrupt), 32'd1);
    tick();
    check_val("t7_timed_out", 32'(interrupt), 32'd0);
    check_val("t7_err_set", 32'(timeout_err[0]), 32'd1);
    cfg_load(3'd0, 32'h3080, 8'd2);
    check_val("t7_err_cleared", 32'(timeout_err[0]), 32'd0);
`else
    check_val("t7_no_timeout_err", 32'(timeout_err), 32'd0);
`endif

    // Asynchronous reset while asserting, then nothing fires after release
    cfg_load(3'd1, 32'h3040, 8'd1);
    macroscopic_pc = 32'h3040;
    tick();
    check_val("t8_fire", 32'(interrupt), 32'd1);
    #1 reset = 1'b0;
    #1;
    check_val("t8_async_int", 32'(interrupt), 32'd0);
    check_val("t8_async_pend", 32'(pending), 32'd0);
    check_val("t8_async_id", 32'(int_id), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
    check_val("t8_after_release", 32'(interrupt), 32'd0);
    macroscopic_pc = 32'h0;
    tick();
    tick();
    check_val("t8_max0_int", 32'(interrupt), 32'd0);
    check_val("t8_max0_pend", 32'(pending), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
